// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: icache request/response, hazard and redirect controls,
// predictor update port and the IF/ID register outputs seen by decode.
interface fetch_stage_if;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        bu_valid;
  logic [31:0] bu_pc;
  logic [31:0] bu_target;
  logic        bu_taken;
  logic [31:0] instru;
  logic [31:0] PC;
  logic [31:0] nPC;
  logic        br_taken;
  logic        deen;

  modport master (
    input  ihit, iload, stall, flush, redirect, redirect_pc, halt,
           bu_valid, bu_pc, bu_target, bu_taken,
    output iREN, iaddr, instru, PC, nPC, br_taken, deen
  );

  modport slave (
    output ihit, iload, stall, flush, redirect, redirect_pc, halt,
           bu_valid, bu_pc, bu_target, bu_taken,
    input  iREN, iaddr, instru, PC, nPC, br_taken, deen
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID latch with a one-entry skid for words returned during a stall.
// Optional direct-mapped branch target buffer enabled by defining FETCH_BTB_EN.
//
// state  | meaning
// FETCH  | iREN high, PC presented to icache
// HOLD   | skid holds a returned word, waiting for stall to drop
// HALTED | fetch stopped, PC frozen until reset
module fetch_stage #(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input logic          CLK,
  input logic          nRST,
  fetch_stage_if.master bus
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        skid_pred;

  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_npc;
  logic        id_br;
  logic        id_valid;

  assign pc_plus4 = fetch_pc + 32'd4;
  assign next_pc  = pred_taken ? pred_target : pc_plus4;

  assign bus.iaddr    = fetch_pc;
  assign bus.iREN     = (state == FETCH);
  assign bus.instru   = id_instr;
  assign bus.PC       = id_pc;
  assign bus.nPC      = id_npc;
  assign bus.br_taken = id_br;
  assign bus.deen     = id_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= FETCH;
      fetch_pc   <= PC_INIT;
      id_instr   <= 32'h0;
      id_pc      <= 32'h0;
      id_npc     <= 32'h0;
      id_br      <= 1'b0;
      id_valid   <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      skid_pred  <= 1'b0;
    end else if (bus.halt) begin
      state    <= HALTED;
      id_instr <= 32'h0;
      id_br    <= 1'b0;
      id_valid <= 1'b0;
    end else if (state == HALTED) begin
      state <= HALTED;
    end else if (bus.redirect) begin
      // Any same-cycle ihit belongs to the wrong path and is dropped.
      state    <= FETCH;
      fetch_pc <= bus.redirect_pc & ~32'h3;
      id_instr <= 32'h0;
      id_br    <= 1'b0;
      id_valid <= 1'b0;
    end else if (bus.flush) begin
      state    <= FETCH;
      id_instr <= 32'h0;
      id_br    <= 1'b0;
      id_valid <= 1'b0;
    end else if (state == HOLD) begin
      if (!bus.stall) begin
        state    <= FETCH;
        id_instr <= skid_instr;
        id_pc    <= skid_pc;
        id_npc   <= skid_pc + 32'd4;
        id_br    <= skid_pred;
        id_valid <= 1'b1;
      end
    end else if (bus.ihit) begin
      if (bus.stall) begin
        state      <= HOLD;
        skid_instr <= bus.iload;
        skid_pc    <= fetch_pc;
        skid_pred  <= pred_taken;
      end else begin
        id_instr <= bus.iload;
        id_pc    <= fetch_pc;
        id_npc   <= pc_plus4;
        id_br    <= pred_taken;
        id_valid <= 1'b1;
      end
      fetch_pc <= next_pc;
    end else if (!bus.stall) begin
      id_instr <= 32'h0;
      id_br    <= 1'b0;
      id_valid <= 1'b0;
    end
  end

`ifdef FETCH_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr;
  logic             unused_bu_lsb;

  assign look_idx      = fetch_pc[IDX_W+1:2];
  assign look_tag      = fetch_pc[31:IDX_W+2];
  assign upd_idx       = bus.bu_pc[IDX_W+1:2];
  assign upd_tag       = bus.bu_pc[31:IDX_W+2];
  assign unused_bu_lsb = ^bus.bu_pc[1:0];

  assign pred_taken  = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag)
                       && btb_ctr[look_idx][1];
  assign pred_target = btb_target[look_idx];
  assign upd_hit     = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  always_comb begin
    upd_ctr = btb_ctr[upd_idx];
    if (!upd_hit)
      upd_ctr = bus.bu_taken ? 2'b10 : 2'b01;
    else if (bus.bu_taken && btb_ctr[upd_idx] != 2'b11)
      upd_ctr = btb_ctr[upd_idx] + 2'b01;
    else if (!bus.bu_taken && btb_ctr[upd_idx] != 2'b00)
      upd_ctr = btb_ctr[upd_idx] - 2'b01;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      btb_valid <= '0;
    else if (bus.bu_valid)
      btb_valid[upd_idx] <= 1'b1;
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge CLK) begin
    if (bus.bu_valid) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= bus.bu_target;
      btb_ctr[upd_idx]    <= upd_ctr;
    end
  end
`else
  localparam int unused_btb_entries = BTB_ENTRIES;
  logic unused_bu;

  assign pred_taken  = 1'b0;
  assign pred_target = 32'h0;
  assign unused_bu   = ^{bus.bu_valid, bus.bu_pc, bus.bu_target, bus.bu_taken};
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: per-cycle stimulus with expected
// iaddr/iREN before the edge and IF/ID contents after it.
module tb_fetch_stage;

  logic CLK;
  logic nRST;
  fetch_stage_if bus ();

  fetch_stage #(.PC_INIT(32'h0000_0000), .BTB_ENTRIES(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

`ifdef FETCH_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  typedef struct {
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] rpc;
    logic        halt;
    logic        bu_valid;
    logic [31:0] bu_pc;
    logic [31:0] bu_target;
    logic        bu_taken;
    logic [31:0] e_iaddr;
    logic        e_iren;
    logic [31:0] e_instru;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic        e_deen;
    logic        e_br;
    logic        chk_pc;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t vec(logic ihit, logic [31:0] iload, logic stall, logic flush,
                               logic redirect, logic [31:0] rpc, logic halt,
                               logic [31:0] e_iaddr, logic e_iren, logic [31:0] e_instru,
                               logic [31:0] e_pc, logic [31:0] e_npc, logic e_deen,
                               logic chk_pc);
    vec_t v;
    v.ihit = ihit; v.iload = iload; v.stall = stall; v.flush = flush;
    v.redirect = redirect; v.rpc = rpc; v.halt = halt;
    v.bu_valid = 1'b0; v.bu_pc = 32'h0; v.bu_target = 32'h0; v.bu_taken = 1'b0;
    v.e_iaddr = e_iaddr; v.e_iren = e_iren; v.e_instru = e_instru;
    v.e_pc = e_pc; v.e_npc = e_npc; v.e_deen = e_deen; v.e_br = 1'b0;
    v.chk_pc = chk_pc;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(vec_t v, string tag);
    bus.ihit = v.ihit; bus.iload = v.iload; bus.stall = v.stall; bus.flush = v.flush;
    bus.redirect = v.redirect; bus.redirect_pc = v.rpc; bus.halt = v.halt;
    bus.bu_valid = v.bu_valid; bus.bu_pc = v.bu_pc; bus.bu_target = v.bu_target;
    bus.bu_taken = v.bu_taken;
    #1;
    check({tag, ".iaddr"}, bus.iaddr, v.e_iaddr);
    check({tag, ".iREN"}, {31'h0, bus.iREN}, {31'h0, v.e_iren});
    @(posedge CLK);
    #1;
    check({tag, ".instru"}, bus.instru, v.e_instru);
    check({tag, ".deen"}, {31'h0, bus.deen}, {31'h0, v.e_deen});
    check({tag, ".br_taken"}, {31'h0, bus.br_taken}, {31'h0, v.e_br});
    if (v.chk_pc) begin
      check({tag, ".PC"}, bus.PC, v.e_pc);
      check({tag, ".nPC"}, bus.nPC, v.e_npc);
    end
    @(negedge CLK);
  endtask

  vec_t tbl [21];
  vec_t v;

  initial begin
    //              ihit iload          st fl rd rpc           ht  iaddr         iren instru         pc            npc      deen chk
    tbl[0]  = vec(1, 32'hA000_0000, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'hA000_0000, 32'h0,        32'h4,   1, 1);
    tbl[1]  = vec(1, 32'hA000_0004, 0, 0, 0, 32'h0,         0, 32'h4,         1, 32'hA000_0004, 32'h4,        32'h8,   1, 1);
    tbl[2]  = vec(0, JUNK,          0, 0, 0, 32'h0,         0, 32'h8,         1, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[3]  = vec(1, 32'hA000_0008, 1, 0, 0, 32'h0,         0, 32'h8,         1, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[4]  = vec(0, JUNK,          1, 0, 0, 32'h0,         0, 32'hC,         0, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[5]  = vec(0, JUNK,          1, 0, 0, 32'h0,         0, 32'hC,         0, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[6]  = vec(0, JUNK,          0, 0, 0, 32'h0,         0, 32'hC,         0, 32'hA000_0008, 32'h8,        32'hC,   1, 1);
    tbl[7]  = vec(1, 32'hA000_000C, 0, 0, 0, 32'h0,         0, 32'hC,         1, 32'hA000_000C, 32'hC,        32'h10,  1, 1);
    tbl[8]  = vec(1, JUNK,          0, 0, 1, 32'h0000_0103, 0, 32'h10,        1, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[9]  = vec(1, 32'hA000_0100, 0, 0, 0, 32'h0,         0, 32'h100,       1, 32'hA000_0100, 32'h100,      32'h104, 1, 1);
    tbl[10] = vec(1, JUNK,          0, 1, 0, 32'h0,         0, 32'h104,       1, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[11] = vec(1, JUNK,          1, 0, 1, 32'hFFFF_FFFC, 0, 32'h104,       1, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[12] = vec(1, 32'hA000_FFFC, 0, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'hA000_FFFC, 32'hFFFF_FFFC, 32'h0,  1, 1);
    tbl[13] = vec(0, JUNK,          0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[14] = vec(1, JUNK,          1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[15] = vec(1, 32'hA000_0000, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[16] = vec(0, JUNK,          1, 1, 0, 32'h0,         0, 32'h4,         0, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[17] = vec(1, 32'hA000_0004, 0, 0, 0, 32'h0,         0, 32'h4,         1, 32'hA000_0004, 32'h4,        32'h8,   1, 1);
    tbl[18] = vec(1, JUNK,          0, 0, 1, 32'h200,       1, 32'h8,         1, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[19] = vec(1, JUNK,          0, 0, 0, 32'h0,         0, 32'h8,         0, 32'h0,         32'h0,        32'h0,   0, 0);
    tbl[20] = vec(1, JUNK,          0, 0, 1, 32'h300,       0, 32'h8,         0, 32'h0,         32'h0,        32'h0,   0, 0);

    bus.ihit = 0; bus.iload = 0; bus.stall = 0; bus.flush = 0; bus.redirect = 0;
    bus.redirect_pc = 0; bus.halt = 0; bus.bu_valid = 0; bus.bu_pc = 0;
    bus.bu_target = 0; bus.bu_taken = 0;
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("reset.instru", bus.instru, 32'h0);
    check("reset.PC", bus.PC, 32'h0);
    check("reset.nPC", bus.nPC, 32'h0);
    check("reset.deen", {31'h0, bus.deen}, 32'h0);
    check("reset.iaddr", bus.iaddr, 32'h0);
    check("reset.iREN", {31'h0, bus.iREN}, 32'h1);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 21; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Reset out of HALTED, fetch two words, then reset mid-cycle.
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    apply(vec(1, 32'hB000_0000, 0, 0, 0, 0, 0, 32'h0, 1, 32'hB000_0000, 32'h0, 32'h4, 1, 1), "rst_a");
    apply(vec(1, 32'hB000_0004, 0, 0, 0, 0, 0, 32'h4, 1, 32'hB000_0004, 32'h4, 32'h8, 1, 1), "rst_b");
    bus.ihit = 1'b1; bus.iload = 32'hC000_0000;
    #2 nRST = 1'b0;
    #1;
    check("midrst.instru", bus.instru, 32'h0);
    check("midrst.PC", bus.PC, 32'h0);
    check("midrst.nPC", bus.nPC, 32'h0);
    check("midrst.deen", {31'h0, bus.deen}, 32'h0);
    check("midrst.iaddr", bus.iaddr, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    apply(vec(1, 32'hC000_0000, 0, 0, 0, 0, 0, 32'h0, 1, 32'hC000_0000, 32'h0, 32'h4, 1, 1), "rst_rel");

    // Predictor: allocate taken entry for 0x40 -> 0x80 while redirecting to 0x40.
    v = vec(0, JUNK, 0, 0, 1, 32'h40, 0, 32'h4, 1, 32'h0, 32'h0, 32'h0, 0, 0);
    v.bu_valid = 1; v.bu_pc = 32'h40; v.bu_target = 32'h80; v.bu_taken = 1;
    apply(v, "btb_alloc");
    v = vec(1, 32'hC000_0040, 0, 0, 0, 0, 0, 32'h40, 1, 32'hC000_0040, 32'h40, 32'h44, 1, 1);
    v.e_br = BTB;
    apply(v, "btb_hit");
    apply(vec(0, JUNK, 0, 0, 0, 0, 0, BTB ? 32'h80 : 32'h44, 1, 0, 0, 0, 0, 0), "btb_tgt");
    for (int k = 0; k < 2; k++) begin
      v = vec(0, JUNK, 0, 0, 0, 0, 0, BTB ? 32'h80 : 32'h44, 1, 0, 0, 0, 0, 0);
      v.bu_valid = 1; v.bu_pc = 32'h40; v.bu_target = 32'h80; v.bu_taken = 0;
      apply(v, $sformatf("btb_nt%0d", k));
    end
    apply(vec(0, JUNK, 0, 0, 1, 32'h40, 0, BTB ? 32'h80 : 32'h44, 1, 0, 0, 0, 0, 0), "btb_redir");
    apply(vec(1, 32'hC000_0040, 0, 0, 0, 0, 0, 32'h40, 1, 32'hC000_0040, 32'h40, 32'h44, 1, 1), "btb_nt_hit");
    apply(vec(0, JUNK, 0, 0, 0, 0, 0, 32'h44, 1, 0, 0, 0, 0, 0), "btb_fallthru");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
